// File: rtl/common_pkg.sv
// Shared types and constants for the decode-stage register file.
//   REG_DATA_W / REG_DEPTH : default register width and register count
//   reg_id_t / reg_data_t  : register index and register value types
//   rf_state_e             : clear-engine states
package common_pkg;

    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned REG_DEPTH  = 32;

    typedef logic [$clog2(REG_DEPTH)-1:0] reg_id_t;
    typedef logic [REG_DATA_W-1:0]        reg_data_t;

    typedef enum logic [0:0] {
        RF_CLEAR,
        RF_RUN
    } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ready               : register file is usable; updates are ignored otherwise
//   clear_req           : drops every pending bit on the next edge
//   read_id             : register indices looked up by the read ports
//   write_en, write_id  : writeback retires the pending bit of write_id
//   reserve_en, reserve_id : issue marks reserve_id as pending
//   read_pending        : pending bit of each read port's register
//   any_pending         : OR of all pending bits
module regfile_scoreboard
    import common_pkg::*;
#(
    parameter int unsigned DEPTH    = REG_DEPTH,
    parameter int unsigned NUM_READ = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ready,
    input  logic                             clear_req,
    input  logic [NUM_READ-1:0][ADDR_W-1:0]  read_id,
    input  logic                             write_en,
    input  logic [ADDR_W-1:0]                write_id,
    input  logic                             reserve_en,
    input  logic [ADDR_W-1:0]                reserve_id,
    output logic [NUM_READ-1:0]              read_pending,
    output logic                             any_pending
);

    logic [DEPTH-1:0] pending_q, pending_d;

    always_comb begin
        pending_d = pending_q;
        if (!ready || clear_req) begin
            pending_d = '0;
        end else begin
            if (write_en) pending_d[write_id] = 1'b0;
            // Applied after the clear so a new producer supersedes the retiring one.
            if (reserve_en) pending_d[reserve_id] = 1'b1;
        end
        if (ZERO_REG != 0) pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        for (int k = 0; k < int'(NUM_READ); k++) begin
            logic hit_w, hit_r, fwd;
            hit_w = write_en && (write_id == read_id[k]);
            hit_r = reserve_en && (reserve_id == read_id[k]);
            // A retiring write forwards its data, so the operand is no longer waiting.
            fwd   = (BYPASS != 0) && hit_w && !hit_r;
            read_pending[k] = ready && pending_q[read_id[k]] && !fwd;
        end
    end

    assign any_pending = |pending_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with pending-write scoreboard and sequential clear engine.
//   clk, rst_n         : clock, asynchronous active-low reset
//   clear_req          : restarts the clear engine from entry 0
//   ready              : clear engine idle, array contents valid
//   read_id/read_data  : NUM_READ combinational read ports
//   read_pending       : pending bit of each read port's register
//   write_en/id/data   : writeback port
//   reserve_en/id      : issue-side destination reservation
//   any_pending        : any register awaiting writeback
module regfile_sb
    import common_pkg::*;
#(
    parameter int unsigned DATA_W   = REG_DATA_W,
    parameter int unsigned DEPTH    = REG_DEPTH,
    parameter int unsigned NUM_READ = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear_req,
    output logic                             ready,
    input  logic [NUM_READ-1:0][ADDR_W-1:0]  read_id,
    output logic [NUM_READ-1:0][DATA_W-1:0]  read_data,
    output logic [NUM_READ-1:0]              read_pending,
    input  logic                             write_en,
    input  logic [ADDR_W-1:0]                write_id,
    input  logic [DATA_W-1:0]                write_data,
    input  logic                             reserve_en,
    input  logic [ADDR_W-1:0]                reserve_id,
    output logic                             any_pending
);

    rf_state_e         state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    // Clear engine: one entry per cycle, DEPTH cycles in total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
        end else begin
            unique case (state_q)
                RF_CLEAR: begin
                    if (clear_req) begin
                        ptr_q <= '0;
                    end else if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                        ptr_q   <= '0;
                        state_q <= RF_RUN;
                    end else begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                    end
                end
                RF_RUN: begin
                    if (clear_req) begin
                        ptr_q   <= '0;
                        state_q <= RF_CLEAR;
                    end
                end
                default: state_q <= RF_CLEAR;
            endcase
        end
    end

    assign ready = (state_q == RF_RUN);

    // No reset on the array so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (state_q == RF_CLEAR) begin
            mem[ptr_q] <= '0;
        end else if (write_en && !((ZERO_REG != 0) && (write_id == '0))) begin
            mem[write_id] <= write_data;
        end
    end

    always_comb begin
        for (int k = 0; k < int'(NUM_READ); k++) begin
            read_data[k] = '0;
            if (ready) begin
                if ((ZERO_REG != 0) && (read_id[k] == '0)) begin
                    read_data[k] = '0;
                end else if ((BYPASS != 0) && write_en && (write_id == read_id[k])) begin
                    read_data[k] = write_data;
                end else begin
                    read_data[k] = mem[read_id[k]];
                end
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_READ (NUM_READ),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .ready        (ready),
        .clear_req    (clear_req),
        .read_id      (read_id),
        .write_en     (write_en),
        .write_id     (write_id),
        .reserve_en   (reserve_en),
        .reserve_id   (reserve_id),
        .read_pending (read_pending),
        .any_pending  (any_pending)
    );

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the integer register file: generic width and depth, NUM_READ combinational read ports, optional hardwired zero register, optional write-to-read bypass.
- Adds a per-register pending-write scoreboard.
- Adds a sequential clear engine that zeroes the array one entry per cycle after reset or on request, so the array can map to distributed RAM.
- Sits in the decode stage: read ports feed operand fetch, writeback drives the write port, and issue drives the reserve port.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers (power of two, >=2).
- NUM_READ, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 always reads 0, is never written and never goes pending.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear_req  in  1  one-cycle pulse; restarts the clear engine.
- ready  out  1  high when the clear engine is idle and the array is valid.
- read_id  in  NUM_READ x ADDR_W  read addresses, packed [NUM_READ-1:0][ADDR_W-1:0], where ADDR_W = $clog2(DEPTH).
- read_data  out  NUM_READ x DATA_W  read data.
- read_pending  out  NUM_READ  pending bit of each addressed register.
- write_en  in  1  writeback strobe.
- write_id  in  ADDR_W  writeback address.
- write_data  in  DATA_W  writeback data.
- reserve_en  in  1  issue marks a destination as pending.
- reserve_id  in  ADDR_W  destination to reserve.
- any_pending  out  1  OR of all pending bits.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to CLEAR, clear pointer = 0, ready = 0.
  - All pending bits = 0, any_pending = 0.
  - Array contents are not reset asynchronously.
- FSM states: CLEAR and RUN.
  - CLEAR writes 0 to entry[ptr] each cycle and increments ptr.
  - When ptr = DEPTH-1 has been written, the next state is RUN and ready goes to 1. Clear takes exactly DEPTH cycles after rst_n deasserts.
  - In RUN, clear_req=1 goes to CLEAR with ptr = 0 and clears all pending bits on the same edge.
  - clear_req asserted during CLEAR restarts ptr at 0.
- While ready=0:
  - write_en and reserve_en are ignored.
  - read_data is forced to 0 and read_pending is forced to 0.
- Reads are combinational (0-cycle latency), in priority order:
  1. If ZERO_REG and read_id = 0, return 0.
  2. Else if BYPASS and write_en and write_id = read_id, return write_data.
  3. Else return entry[read_id].
- Writes: entry[write_id] <= write_data on the rising edge when write_en && ready. With ZERO_REG, a write to id 0 is discarded.
- Scoreboard:
  - reserve_en && ready sets pending[reserve_id] on the next edge.
  - write_en && ready clears pending[write_id].
  - Same id, same cycle: reserve wins and the bit stays 1 (new producer supersedes).
  - Different ids in the same cycle: both actions take effect.
  - read_pending[k] = pending[read_id[k]], combinational.
  - With BYPASS, read_pending[k] = 0 when write_en && write_id = read_id[k] && !(reserve_en && reserve_id = read_id[k]).
  - With ZERO_REG, pending[0] is constant 0.
- Multiple read ports addressing the same id all return identical data.
- Ids are always in range (DEPTH is a power of two), so there is no wrap-around case.
- rst_n asserted mid-operation (any state) aborts immediately; the clear restarts when reset is released.

Decomposition:
- common_pkg gains:
  - REG_DATA_W = 32 and REG_DEPTH = 32 constants.
  - typedef reg_id_t = logic [$clog2(REG_DEPTH)-1:0].
  - typedef reg_data_t = logic [REG_DATA_W-1:0].
  - enum rf_state_e {RF_CLEAR, RF_RUN}.
- One natural sub-module: regfile_scoreboard, holding the pending vector, reserve/clear priority, the read_pending muxes and any_pending.
- Array, clear FSM and read muxes stay in regfile_sb.

Test Plan:
- Reset release -> ready=0 for exactly 32 cycles, then ready=1; every read_id returns 0x00000000 and any_pending=0.
- In RUN, write id 5 = 0xDEADBEEF, then next cycle read port0 id 5 -> 0xDEADBEEF; write id 0 = 0x1234 -> port1 id 0 reads 0.
- BYPASS: same cycle write_en, id 7 = 0xA5A5A5A5 with read port1 id 7 -> read_data[1] = 0xA5A5A5A5 combinationally, read_pending[1]=0.
- Reserve id 3 -> read_pending=1 and any_pending=1 next cycle. Then reserve 3 and write 3 (0x11) in the same cycle -> pending stays 1, entry reads 0x11. Then write 3 alone -> pending clears, any_pending=0.
- In RUN, write id 9 = 0x55 and reserve id 9, then pulse clear_req:
  - ready=0 for 32 cycles, and write_en during this window is ignored.
  - Afterwards id 9 reads 0 and pending=0.
- Drop rst_n mid-CLEAR (ptr ~ 10) and mid-RUN -> ready=0 and pending cleared immediately (asynchronous); full 32-cycle clear after release. Repeat with DEPTH=16, NUM_READ=3, ZERO_REG=0 -> 16-cycle clear and id 0 writable.
